rdata_chan_mngr: RTL and testbench

- Manager-side AXI read data channel.
- Accepts a fixed 4-beat, 32-bit R burst from the subordinate's read data channel and assembles the beats into one 128-bit line with its ID.
- Hands the line to the requesting logic (cache fill / fetch side) through a level valid/ready pair.
- Checks burst framing (RLAST position, RID consistency) and flags violations with a sticky error.

---
 rtl/rdata_chan_mngr.sv | 113 +++++++++++
 tb/tb_rdata_chan_mngr.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rdata_chan_mngr.sv
// rdata_chan_mngr
// Manager-side AXI read data channel. Collects a fixed 4-beat, 32-bit R
// burst into one 128-bit line with its ID and offers it to the consumer on
// a level valid/ready pair. Burst framing (RLAST position and, optionally,
// RID consistency) is checked on every accepted beat. A violation parks the
// block in a sticky error state until reset.
//
// Ports
//   clk            clock, all state on rising edge
//   rst            asynchronous reset, active-high
//   rvalid/rready  R channel handshake with the subordinate
//   rid/rdata/rlast R channel payload
//   rdata_m_valid  assembled line valid (level, held until accepted)
//   rdata_m_ready  consumer accepts the line
//   rdata_m_id     ID of the assembled line (RID of beat 0)
//   rdata_m_data   assembled line, beat 0 in [31:0]
//   rdata_m_err    sticky protocol error
module rdata_chan_mngr #(
  parameter bit ID_CHECK = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rvalid,
  output logic         rready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic         rlast,
  output logic         rdata_m_valid,
  input  logic         rdata_m_ready,
  output logic [3:0]   rdata_m_id,
  output logic [127:0] rdata_m_data,
  output logic         rdata_m_err
);

  typedef enum logic [1:0] {
    RDAT_MRECV = 2'b00,
    RDAT_MFULL = 2'b01,
    RDAT_MERR  = 2'b10,
    RDAT_MDEFO = 2'b11
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     cntr_q, cntr_d;
  logic [127:0]   data_q, data_d;
  logic [3:0]     id_q, id_d;
  logic           beat;
  logic           frame_err;

  // Handshake outputs are pure decodes of the state register, so they are
  // glitch-free and need no separate registers.
  assign rready        = (state_q == RDAT_MRECV);
  assign rdata_m_valid = (state_q == RDAT_MFULL);
  assign rdata_m_err   = (state_q == RDAT_MERR);
  assign rdata_m_data  = data_q;
  assign rdata_m_id    = id_q;

  assign beat = rvalid & rready;

  // RID is compared against the ID latched on beat 0; beat 0 itself can
  // never mismatch.
  assign frame_err = beat & (
                       (rlast  & (cntr_q != 2'd3)) |
                       (!rlast & (cntr_q == 2'd3)) |
                       (ID_CHECK && (cntr_q != 2'd0) && (rid != id_q)));

  always_comb begin
    state_d = state_q;
    cntr_d  = cntr_q;
    data_d  = data_q;
    id_d    = id_q;
    case (state_q)
      RDAT_MRECV: begin
        if (beat) begin
          cntr_d = cntr_q + 2'd1;
          case (cntr_q)
            2'd0:    data_d[31:0]   = rdata;
            2'd1:    data_d[63:32]  = rdata;
            2'd2:    data_d[95:64]  = rdata;
            default: data_d[127:96] = rdata;
          endcase
          if (cntr_q == 2'd0) id_d = rid;
          if (frame_err)
            state_d = RDAT_MERR;
          else if (cntr_q == 2'd3)
            state_d = RDAT_MFULL;
        end
      end
      RDAT_MFULL: begin
        if (rdata_m_ready) begin
          state_d = RDAT_MRECV;
          cntr_d  = 2'd0;
        end
      end
      RDAT_MERR:  state_d = RDAT_MERR;
      default:    state_d = RDAT_MDEFO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RDAT_MRECV;
      cntr_q  <= 2'd0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cntr_q  <= cntr_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

endmodule

// File: tb/tb_rdata_chan_mngr.sv
module tb_rdata_chan_mngr;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rvalid = 1'b0;
  logic [3:0]   rid = '0;
  logic [31:0]  rdata = '0;
  logic         rlast = 1'b0;
  logic         m_ready = 1'b1;

  logic         rready1, valid1, err1;
  logic [3:0]   id1;
  logic [127:0] data1;
  logic         rready0, valid0, err0;
  logic [3:0]   id0;
  logic [127:0] data0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rdata_chan_mngr #(.ID_CHECK(1'b1)) dut1 (
    .clk(clk), .rst(rst), .rvalid(rvalid), .rready(rready1), .rid(rid),
    .rdata(rdata), .rlast(rlast), .rdata_m_valid(valid1),
    .rdata_m_ready(m_ready), .rdata_m_id(id1), .rdata_m_data(data1),
    .rdata_m_err(err1));

  rdata_chan_mngr #(.ID_CHECK(1'b0)) dut0 (
    .clk(clk), .rst(rst), .rvalid(rvalid), .rready(rready0), .rid(rid),
    .rdata(rdata), .rlast(rlast), .rdata_m_valid(valid0),
    .rdata_m_ready(m_ready), .rdata_m_id(id0), .rdata_m_data(data0),
    .rdata_m_err(err0));

  typedef struct packed {
    logic [3:0]   id;
    logic [127:0] data;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];

  typedef struct {
    logic [3:0][3:0]  id;
    logic [3:0][31:0] d;
    logic [3:0]       last;
    logic [3:0][1:0]  gap;
    int               err_at1;  // beat index where ID_CHECK=1 instance errors, 4 = none
    int               err_at0;  // same for ID_CHECK=0 instance
  } burst_t;

  burst_t vecs[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: on every handshake seen before the edge, pop and compare.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid1 && m_ready) begin
        if (q1.size() == 0) chk("dut1_unexpected_line", 1'b1, 1'b0);
        else begin
          exp_t e;
          e = q1.pop_front();
          chk("dut1_line_data", data1, e.data);
          chk("dut1_line_id", {124'd0, id1}, {124'd0, e.id});
          chk("dut1_line_err", {127'd0, err1}, 128'd0);
        end
      end
      if (valid0 && m_ready) begin
        if (q0.size() == 0) chk("dut0_unexpected_line", 1'b1, 1'b0);
        else begin
          exp_t e;
          e = q0.pop_front();
          chk("dut0_line_data", data0, e.data);
          chk("dut0_line_id", {124'd0, id0}, {124'd0, e.id});
        end
      end
    end
  end

  // Drive one beat and hold it until the selected instance takes it.
  // Returns at posedge+1 after the accepting edge, rvalid still high.
  task automatic send_beat(input bit sel, input logic [3:0] i_id,
                           input logic [31:0] i_d, input logic i_last);
    int n;
    rvalid = 1'b1;
    rid    = i_id;
    rdata  = i_d;
    rlast  = i_last;
    n = 0;
    forever begin
      @(negedge clk);
      if (sel ? rready1 : rready0) break;
      n++;
      if (n > 50) begin
        chk("beat_timeout", 1'b0, 1'b1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rvalid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && (q1.size() != 0 || q0.size() != 0); k++) @(posedge clk);
    #1;
    chk("drain_q1", q1.size(), 0);
    chk("drain_q0", q0.size(), 0);
  endtask

  // Reset asserted away from the clock edge; outputs must clear at once.
  task automatic async_reset();
    rvalid = 1'b0;
    @(posedge clk);
    #4 rst = 1'b1;
    #1;
    chk("rst_rready1", rready1, 1'b1);
    chk("rst_rready0", rready0, 1'b1);
    chk("rst_valid", {valid1, valid0}, 2'b00);
    chk("rst_err", {err1, err0}, 2'b00);
    chk("rst_data1", data1, 128'd0);
    chk("rst_data0", data0, 128'd0);
    chk("rst_id", {id1, id0}, 8'd0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input burst_t v);
    int live;
    if (v.err_at1 == 4) q1.push_back({v.id[0], v.d});
    if (v.err_at0 == 4) q0.push_back({v.id[0], v.d});
    for (int i = 0; i < 4; i++) begin
      if (i <= v.err_at1) live = 1;
      else if (i <= v.err_at0) live = 0;
      else live = -1;
      if (live < 0) break;
      if (v.gap[i] != 0) idle(int'(v.gap[i]));
      if (i == 3 && v.err_at1 == 4)
        chk("valid_before_last", {valid1, valid0}, 2'b00);
      send_beat(live == 1, v.id[i], v.d[i], v.last[i]);
    end
    rvalid = 1'b0;
    if (v.err_at1 == 4 && v.err_at0 == 4) begin
      chk("valid_after_last", {valid1, valid0}, 2'b11);
      chk("rready_in_full", {rready1, rready0}, 2'b00);
      drain();
    end else begin
      chk("err1_flag", err1, v.err_at1 != 4);
      chk("err0_flag", err0, v.err_at0 != 4);
      chk("err1_rready", rready1, v.err_at1 == 4);
      chk("err1_valid", valid1, 1'b0);
      idle(3);
      chk("err_sticky", {err1, rready1}, {v.err_at1 != 4, v.err_at1 == 4});
      chk("err_valid_low", {valid1, err0 & valid0}, 2'b00);
      drain();
      async_reset();
    end
  endtask

  initial begin
    burst_t x, y;

    vecs[0].id = {4'h5, 4'h5, 4'h5, 4'h5};
    vecs[0].d  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    vecs[0].last = 4'b1000;
    vecs[0].gap  = {2'd0, 2'd0, 2'd0, 2'd0};
    vecs[0].err_at1 = 4; vecs[0].err_at0 = 4;

    vecs[1] = vecs[0];
    vecs[1].gap = {2'd3, 2'd0, 2'd2, 2'd0};

    vecs[2].id = {4'hA, 4'hA, 4'hA, 4'hA};
    vecs[2].d  = {32'hFFFFFFFF, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF};
    vecs[2].last = 4'b1000;
    vecs[2].gap  = {2'd0, 2'd1, 2'd0, 2'd1};
    vecs[2].err_at1 = 4; vecs[2].err_at0 = 4;

    vecs[3].id = {4'h4, 4'h4, 4'h3, 4'h3};
    vecs[3].d  = {32'hD0D0D0D0, 32'hC0C0C0C0, 32'hB0B0B0B0, 32'hA0A0A0A0};
    vecs[3].last = 4'b1000;
    vecs[3].gap  = {2'd0, 2'd0, 2'd0, 2'd0};
    vecs[3].err_at1 = 2; vecs[3].err_at0 = 4;

    vecs[4] = vecs[0];
    vecs[4].last = 4'b0010;
    vecs[4].err_at1 = 1; vecs[4].err_at0 = 1;

    vecs[5] = vecs[2];
    vecs[5].last = 4'b0000;
    vecs[5].gap  = {2'd0, 2'd0, 2'd0, 2'd0};
    vecs[5].err_at1 = 3; vecs[5].err_at0 = 3;

    // Power-on reset, released off the clock edge.
    #12;
    chk("init_rready", {rready1, rready0}, 2'b11);
    chk("init_valid_err", {valid1, valid0, err1, err0}, 4'b0000);
    chk("init_data", data1, 128'd0);
    chk("init_id", {id1, id0}, 8'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 6; v++) run_vec(vecs[v]);

    // Consumer stall with the next burst already pending.
    x = vecs[2];
    y = vecs[0];
    y.d = {32'h0F0F0F0F, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'hF0F0F0F0};
    y.id = {4'h9, 4'h9, 4'h9, 4'h9};
    m_ready = 1'b0;
    q1.push_back({x.id[0], x.d}); q0.push_back({x.id[0], x.d});
    q1.push_back({y.id[0], y.d}); q0.push_back({y.id[0], y.d});
    for (int i = 0; i < 4; i++) send_beat(1'b1, x.id[i], x.d[i], x.last[i]);
    rvalid = 1'b1; rid = y.id[0]; rdata = y.d[0]; rlast = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("stall_rready", {rready1, rready0}, 2'b00);
      chk("stall_valid", {valid1, valid0}, 2'b11);
      chk("stall_data", data1, x.d);
      chk("stall_id", {124'd0, id1}, {124'd0, x.id[0]});
    end
    @(posedge clk);
    #1 m_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("unstall_rready", {rready1, rready0}, 2'b11);
    chk("unstall_valid", {valid1, valid0}, 2'b00);
    for (int i = 0; i < 4; i++) send_beat(1'b1, y.id[i], y.d[i], y.last[i]);
    rvalid = 1'b0;
    chk("stall_second_valid", {valid1, valid0}, 2'b11);
    drain();

    // Reset after two beats: partial line discarded, next burst starts at beat 0.
    send_beat(1'b1, 4'h7, 32'h12345678, 1'b0);
    send_beat(1'b1, 4'h7, 32'h9ABCDEF0, 1'b0);
    async_reset();
    x = vecs[2];
    x.id = {4'h6, 4'h6, 4'h6, 4'h6};
    x.gap = {2'd0, 2'd0, 2'd0, 2'd0};
    run_vec(x);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
